// File: rtl/phy_tx_arb_if.sv
// phy_tx_arb_if
// Groups the two frame-source handshakes and the TX PHY queue write port
// that phy_tx_arb arbitrates between.
//
// Signals
//   sN_req    : source N has a complete frame ready
//   sN_gnt    : source N currently owns the queue write port
//   sN_din    : source N byte, bit8 = 1 for frame bytes
//   sN_wr_en  : source N byte strobe
//   sN_last   : marks the final byte of the source N frame
//   sN_full   : backpressure to source N
//   phy_din   : byte towards the TX PHY queue
//   phy_wr_en : write strobe towards the TX PHY queue
//   phy_full  : full flag from the TX PHY queue
//
// Modports
//   master : the frame sources and the queue (drive requests, bytes, full)
//   slave  : the arbiter
interface phy_tx_arb_if;
  logic       s0_req;
  logic       s0_gnt;
  logic [8:0] s0_din;
  logic       s0_wr_en;
  logic       s0_last;
  logic       s0_full;
  logic       s1_req;
  logic       s1_gnt;
  logic [8:0] s1_din;
  logic       s1_wr_en;
  logic       s1_last;
  logic       s1_full;
  logic [8:0] phy_din;
  logic       phy_wr_en;
  logic       phy_full;

  modport master (
    output s0_req, s0_din, s0_wr_en, s0_last,
    output s1_req, s1_din, s1_wr_en, s1_last,
    output phy_full,
    input  s0_gnt, s0_full, s1_gnt, s1_full,
    input  phy_din, phy_wr_en
  );

  modport slave (
    input  s0_req, s0_din, s0_wr_en, s0_last,
    input  s1_req, s1_din, s1_wr_en, s1_last,
    input  phy_full,
    output s0_gnt, s0_full, s1_gnt, s1_full,
    output phy_din, phy_wr_en
  );
endinterface

// File: rtl/phy_tx_arb.sv
// phy_tx_arb
// Frame-granular round-robin arbiter sharing the single write port of the
// TX PHY queue between two frame sources. A granted frame is passed through
// combinationally byte by byte; after it the arbiter appends GAP zero bytes
// so the downstream GMII converter sees contiguous, delimited frames.
// Frames exceeding MAX_LEN data bytes are cut and counted in drop_cnt.
//
// Ports
//   pcie_clk : clock
//   sys_rst  : synchronous active-high reset
//   bus      : phy_tx_arb_if.slave (source handshakes + queue write port)
//   drop_cnt : saturating count of frames cut by the length limit
//   frm_cnt0 : (PHY_TX_ARB_STATS_EN only) completed frames from source 0
//   frm_cnt1 : (PHY_TX_ARB_STATS_EN only) completed frames from source 1
//
// Optional feature macro: PHY_TX_ARB_STATS_EN adds the per-source frame
// counters; without it the counters and their ports do not exist.
module phy_tx_arb #(
  parameter logic [3:0]  GAP     = 4'd2,
  parameter logic [10:0] MAX_LEN = 11'd1518
) (
  input  logic         pcie_clk,
  input  logic         sys_rst,
  phy_tx_arb_if.slave  bus,
  output logic [7:0]   drop_cnt
`ifdef PHY_TX_ARB_STATS_EN
  ,
  output logic [15:0]  frm_cnt0,
  output logic [15:0]  frm_cnt1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_src;
  logic [10:0] r_len;
  logic [3:0]  r_gap_cnt;
  logic [7:0]  r_drop_cnt;

  state_t      w_state_nxt;
  logic        w_last_src_nxt;
  logic [10:0] w_len_nxt;
  logic [3:0]  w_gap_nxt;
  logic [7:0]  w_drop_nxt;
  logic        w_end0;
  logic        w_end1;

  logic        w_granted;
  logic        w_cur_src;
  logic [8:0]  w_sel_din;
  logic        w_sel_wr_en;
  logic        w_sel_last;
  logic        w_acc;
  state_t      w_after_frame;

  // Byte-mux selection follows the registered grant state only.
  assign w_granted   = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_cur_src   = (r_state == ST_GRANT1);
  assign w_sel_din   = w_cur_src ? bus.s1_din   : bus.s0_din;
  assign w_sel_wr_en = w_cur_src ? bus.s1_wr_en : bus.s0_wr_en;
  assign w_sel_last  = w_cur_src ? bus.s1_last  : bus.s0_last;
  assign w_acc       = w_granted & w_sel_wr_en & ~bus.phy_full;

  // With no gap configured a finished frame returns straight to IDLE.
  assign w_after_frame = (GAP == 4'd0) ? ST_IDLE : ST_GAP;

  // Grant and backpressure decode: only the granted source sees the real
  // queue full flag, everyone else is held off with full = 1.
  assign bus.s0_gnt  = (r_state == ST_GRANT0);
  assign bus.s1_gnt  = (r_state == ST_GRANT1);
  assign bus.s0_full = (r_state == ST_GRANT0) ? bus.phy_full : 1'b1;
  assign bus.s1_full = (r_state == ST_GRANT1) ? bus.phy_full : 1'b1;
  assign drop_cnt    = r_drop_cnt;

  // Queue write port: zero-latency passthrough while granted, zero gap bytes
  // in GAP, idle otherwise.
  always_comb begin
    bus.phy_din   = 9'h000;
    bus.phy_wr_en = 1'b0;
    case (r_state)
      ST_GRANT0, ST_GRANT1: begin
        bus.phy_din   = w_sel_din;
        bus.phy_wr_en = w_sel_wr_en & ~bus.phy_full;
      end
      ST_GAP: begin
        bus.phy_din   = 9'h000;
        bus.phy_wr_en = ~bus.phy_full;
      end
      default: begin
        bus.phy_din   = 9'h000;
        bus.phy_wr_en = 1'b0;
      end
    endcase
  end

  // Next-state logic: round-robin pick in IDLE, frame tracking in GRANT,
  // gap byte counting in GAP.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_src_nxt = r_last_src;
    w_len_nxt      = r_len;
    w_gap_nxt      = r_gap_cnt;
    w_drop_nxt     = r_drop_cnt;
    w_end0         = 1'b0;
    w_end1         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.s0_req && bus.s1_req) begin
          // Tie goes to the source that did not send the previous frame.
          w_state_nxt = r_last_src ? ST_GRANT0 : ST_GRANT1;
        end else if (bus.s0_req) begin
          w_state_nxt = ST_GRANT0;
        end else if (bus.s1_req) begin
          w_state_nxt = ST_GRANT1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (w_acc) begin
          if (w_sel_last) begin
            // A last byte on the limit still counts as a normal end.
            w_last_src_nxt = w_cur_src;
            w_len_nxt      = 11'd0;
            w_state_nxt    = w_after_frame;
            w_end0         = ~w_cur_src;
            w_end1         = w_cur_src;
          end else if ((r_len + 11'd1) == MAX_LEN) begin
            // Cut the frame; the source also loses the next tie so an
            // oversize stream cannot starve the other source.
            w_last_src_nxt = w_cur_src;
            w_len_nxt      = 11'd0;
            w_state_nxt    = w_after_frame;
            w_drop_nxt     = (r_drop_cnt == 8'hff) ? 8'hff : (r_drop_cnt + 8'd1);
          end else begin
            w_len_nxt = r_len + 11'd1;
          end
        end else begin
          w_len_nxt = r_len;
        end
      end
      ST_GAP: begin
        if (!bus.phy_full) begin
          if ((r_gap_cnt + 4'd1) == GAP) begin
            w_gap_nxt   = 4'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_gap_nxt = r_gap_cnt + 4'd1;
          end
        end else begin
          w_gap_nxt = r_gap_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_last_src <= 1'b1;
      r_len      <= 11'd0;
      r_gap_cnt  <= 4'd0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_src <= w_last_src_nxt;
      r_len      <= w_len_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

`ifdef PHY_TX_ARB_STATS_EN
  logic [15:0] r_frm_cnt0;
  logic [15:0] r_frm_cnt1;

  assign frm_cnt0 = r_frm_cnt0;
  assign frm_cnt1 = r_frm_cnt1;

  // Per-source completed-frame counters, wrapping at 16 bits.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_frm_cnt0 <= 16'd0;
      r_frm_cnt1 <= 16'd0;
    end else begin
      if (w_end0) begin
        r_frm_cnt0 <= r_frm_cnt0 + 16'd1;
      end
      if (w_end1) begin
        r_frm_cnt1 <= r_frm_cnt1 + 16'd1;
      end
    end
  end
`else
  logic w_unused_end;
  assign w_unused_end = w_end0 | w_end1;
`endif

endmodule
